// File: rtl/cordic_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// cordic_request_arbiter_if
//
// Bundles the handshake between the two theta requesters, the arbiter and the
// shared theta-to-dt_ticks CORDIC engine.
//
//   req0_valid_i / req0_theta_i / req0_ready_o  requester 0 request channel
//   req1_valid_i / req1_theta_i / req1_ready_o  requester 1 request channel
//   rsp0_valid_o, rsp1_valid_o                  one-cycle result pulses
//   rsp_data_o, rsp_timeout_o                   result data and abort flag
//   busy_o                                      arbiter not idle
//   theta_iteration_valid_o / theta_iteration_o theta towards the engine
//   dt_Ticks_valid_i / dt_Ticks_i               engine result
//   next_dt_Ticks_i                             engine ready for next theta
//
// Modports: slave = arbiter view, master = requesters + engine view.
// ---------------------------------------------------------------------------
interface cordic_request_arbiter_if #(
    parameter int THETA_W = 12,
    parameter int TICK_W  = 16
);
    logic               req0_valid_i;
    logic [THETA_W-1:0] req0_theta_i;
    logic               req0_ready_o;
    logic               req1_valid_i;
    logic [THETA_W-1:0] req1_theta_i;
    logic               req1_ready_o;
    logic               rsp0_valid_o;
    logic               rsp1_valid_o;
    logic [TICK_W-1:0]  rsp_data_o;
    logic               rsp_timeout_o;
    logic               busy_o;
    logic               theta_iteration_valid_o;
    logic [THETA_W-1:0] theta_iteration_o;
    logic               dt_Ticks_valid_i;
    logic               next_dt_Ticks_i;
    logic [TICK_W-1:0]  dt_Ticks_i;

    modport slave (
        input  req0_valid_i, req0_theta_i, req1_valid_i, req1_theta_i,
        input  dt_Ticks_valid_i, next_dt_Ticks_i, dt_Ticks_i,
        output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
        output rsp_data_o, rsp_timeout_o, busy_o,
        output theta_iteration_valid_o, theta_iteration_o
    );

    modport master (
        output req0_valid_i, req0_theta_i, req1_valid_i, req1_theta_i,
        output dt_Ticks_valid_i, next_dt_Ticks_i, dt_Ticks_i,
        input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
        input  rsp_data_o, rsp_timeout_o, busy_o,
        input  theta_iteration_valid_o, theta_iteration_o
    );
endinterface

// File: rtl/cordic_request_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_request_arbiter
//
// Shares one theta-to-dt_ticks CORDIC engine between two requesters. Grants
// round-robin from IDLE, presents one theta at a time to the engine, routes
// the tick result back to the owner as a one-cycle pulse, and aborts through
// a watchdog if the engine stalls in either phase.
//
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    cordic_request_arbiter_if.slave (requesters, responses, engine)
// ---------------------------------------------------------------------------
module cordic_request_arbiter #(
    parameter int THETA_W   = 12,
    parameter int TICK_W    = 16,
    parameter int TIMEOUT_P = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    cordic_request_arbiter_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_READY = 2'd2
    } state_t;

    // Watchdog fires in the TIMEOUT_P-th cycle of a phase.
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_P - 1);

    state_t             state;
    logic               last_grant;
    logic               owner;
    logic [7:0]         wdog;
    logic               theta_valid;
    logic [THETA_W-1:0] theta_q;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic               rsp_timeout;
    logic [TICK_W-1:0]  rsp_data;

    logic               grant_any;
    logic               grant_sel;
    logic               wdog_expired;

    // Grant is combinational so the winner sees ready in the same IDLE cycle.
    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                grant_any = 1'b1;
                grant_sel = ~last_grant;
            end else if (bus.req0_valid_i) begin
                grant_any = 1'b1;
                grant_sel = 1'b0;
            end else if (bus.req1_valid_i) begin
                grant_any = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign wdog_expired = (wdog == WDOG_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            wdog        <= '0;
            theta_valid <= 1'b0;
            theta_q     <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_data    <= '0;
        end else begin
            // Response strobes are single-cycle pulses.
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        theta_q     <= grant_sel ? bus.req1_theta_i : bus.req0_theta_i;
                        owner       <= grant_sel;
                        last_grant  <= grant_sel;
                        wdog        <= '0;
                        theta_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.dt_Ticks_valid_i) begin
                        rsp_data    <= bus.dt_Ticks_i;
                        rsp0_valid  <= ~owner;
                        rsp1_valid  <= owner;
                        theta_valid <= 1'b0;
                        wdog        <= '0;
                        // Engine may already be ready again: skip WAIT_READY.
                        state       <= bus.next_dt_Ticks_i ? IDLE : WAIT_READY;
                    end else if (wdog_expired) begin
                        rsp_data    <= '0;
                        rsp0_valid  <= ~owner;
                        rsp1_valid  <= owner;
                        rsp_timeout <= 1'b1;
                        theta_valid <= 1'b0;
                        wdog        <= '0;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                WAIT_READY: begin
                    // The result was already delivered, so an abort here is silent.
                    if (bus.next_dt_Ticks_i || wdog_expired) begin
                        wdog  <= '0;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                default: begin
                    theta_valid <= 1'b0;
                    wdog        <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready_o            = grant_any & ~grant_sel;
    assign bus.req1_ready_o            = grant_any & grant_sel;
    assign bus.rsp0_valid_o            = rsp0_valid;
    assign bus.rsp1_valid_o            = rsp1_valid;
    assign bus.rsp_data_o              = rsp_data;
    assign bus.rsp_timeout_o           = rsp_timeout;
    assign bus.busy_o                  = (state != IDLE);
    assign bus.theta_iteration_valid_o = theta_valid;
    assign bus.theta_iteration_o       = theta_q;

endmodule

// File: doc/cordic_request_arbiter.md
# cordic_request_arbiter

Shares the single theta-to-dt_ticks CORDIC engine (cordicManager) between two independent requesters, e.g. the edge-tick/table builder and a calibration or frequency-tracking unit. It arbitrates round-robin, issues one theta at a time using the engine's valid / result / next-ready protocol, and routes the tick result back to the owning requester. A watchdog prevents a stalled engine from locking the requesters out.

## Interface
- THETA_W, 12, theta index width
- TICK_W, 16, dt_ticks result width
- TIMEOUT_P, 255, max cycles the engine may take per phase (ISSUE or WAIT_READY) before abort; 1..255
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- req0_valid_i  in  1  requester 0 has a theta pending
- req0_theta_i  in  THETA_W  requester 0 theta
- req0_ready_o  out  1  requester 0 accepted this cycle
- req1_valid_i / req1_theta_i / req1_ready_o  same for requester 1
- rsp0_valid_o  out  1  one-cycle pulse, result for requester 0
- rsp1_valid_o  out  1  one-cycle pulse, result for requester 1
- rsp_data_o  out  TICK_W  result, valid with rsp*_valid_o
- rsp_timeout_o  out  1  qualifies rsp*_valid_o; 1 = aborted, data = 0
- busy_o  out  1  state != IDLE
- theta_iteration_valid_o  out  1  to engine theta_iteration_valid_i
- theta_iteration_o  out  THETA_W  to engine theta_iteration_i
- dt_Ticks_valid_i  in  1  engine result valid
- next_dt_Ticks_i  in  1  engine ready for next theta
- dt_Ticks_i  in  TICK_W  engine result

## Operation
- States: IDLE, ISSUE, WAIT_READY.
- IDLE: grant is combinational from the valids and last_grant. With one valid, that requester wins. With both valid, the requester != last_grant wins. The winner's readyN_o = 1 in that cycle; the other stays 0. On grant: latch theta and owner, set last_grant = owner, clear watchdog, go to ISSUE.
- readyN_o = 0 in every state except IDLE.
- ISSUE: theta_iteration_valid_o = 1 and theta_iteration_o = the latched theta, held steady. On dt_Ticks_valid_i:
  - latch dt_Ticks_i and pulse the owner's rsp valid next cycle with rsp_timeout_o = 0;
  - if next_dt_Ticks_i is also high in the same cycle, go to IDLE; otherwise go to WAIT_READY.
- WAIT_READY: theta_iteration_valid_o = 0. On next_dt_Ticks_i, go to IDLE. A stray dt_Ticks_valid_i here is ignored.
- In IDLE, dt_Ticks_valid_i and next_dt_Ticks_i are ignored.
- Watchdog: an 8-bit counter increments every cycle in ISSUE and in WAIT_READY and clears on each state change. When it equals TIMEOUT_P-1 and the state's exit event is absent, abort:
  - go to IDLE and drop theta valid;
  - if the abort happens in ISSUE, pulse the owner's rsp valid with rsp_timeout_o = 1 and rsp_data_o = 0;
  - if it happens in WAIT_READY, no response pulse is issued (the result was already delivered).
- Widths: no arithmetic on data. Theta and result pass through unmodified.

## Timing
- Reset values: all rsp*_valid_o, rsp_timeout_o, busy_o, theta_iteration_valid_o = 0. theta_iteration_o = 0, rsp_data_o = 0, state = IDLE, last_grant = 1 (so requester 0 wins the first tie).
- Reset asserted mid-operation: the next edge forces IDLE and the reset values. Any in-flight result is dropped and no rsp pulse is issued.
- Accept at edge N (validN & readyN). Then theta_iteration_valid_o = 1 from cycle N+1.
- Result: dt_Ticks_valid_i sampled at edge M gives rsp pulse and data during cycle M+1, exactly one cycle wide.
- Back-to-back throughput: next_dt_Ticks_i sampled at edge K puts the state in IDLE in cycle K+1, so the next grant is possible in cycle K+1.
- A requester must hold valid and theta until ready. Dropping valid before grant withdraws the request without error.
- rsp_data_o holds its last value between pulses. It is cleared only by reset or a timeout response.

## Test plan
- Single request: req0 theta = 0x123, engine returns 0x4A5 three cycles after valid, next_dt two cycles later. Required: req0_ready one cycle; theta_iteration_valid_o high for exactly three cycles; rsp0_valid pulse with data 0x4A5; rsp1_valid stays 0; busy_o drops after next_dt.
- Tie after reset: both valid, thetas 5 and 9. Required: req0 granted first (engine sees 5), then req1 (engine sees 9); responses route to rsp0 and then rsp1.
- Fairness under saturation: both requesters always valid for 6 transactions. Required: grants alternate 0,1,0,1,0,1 and no requester starves.
- Same-cycle dt_Ticks_valid and next_dt_Ticks: required rsp pulse, IDLE next cycle, and a new grant possible in that IDLE cycle.
- Timeout: TIMEOUT_P = 10, engine never answers. Required: theta valid drops after 10 ISSUE cycles; the owner gets an rsp pulse with rsp_timeout_o = 1 and data 0; the other requester is granted next.
- Reset mid-ISSUE: rst_i high for one cycle. Required: all outputs at reset values the next cycle, no rsp pulse, and a subsequent tie grants req0.
